// File: rtl/row_col_dec_pkg.sv
// Shared DCO selector definitions: default widths, array size derivation and
// err_code bit positions used by the row/column decoder.
package row_col_dec_pkg;

    localparam int unsigned ROW_W_DEF     = 4;
    localparam int unsigned WORD_W_DEF    = 2 * ROW_W_DEF;
    localparam int unsigned ERR_CNT_W_DEF = 8;

    localparam int unsigned ERR_CODE_W = 3;
    localparam int unsigned ERR_RALL   = 0;
    localparam int unsigned ERR_ROW    = 1;
    localparam int unsigned ERR_COL    = 2;

    typedef enum logic {
        FillLsb = 1'b0,
        FillMsb = 1'b1
    } fill_e;

    function automatic int unsigned size_of(input int unsigned row_w);
        return 32'd1 << row_w;
    endfunction

endpackage

// File: rtl/row_col_dec_therm_ones_cnt.sv
// Combinational thermometer analyser: counts the fill run or the population of
// active bits and flags whether the active bits form one run from the fill end.
module row_col_dec_therm_ones_cnt import row_col_dec_pkg::*; #(
    parameter int unsigned SIZE        = 16,
    parameter int unsigned CNT_W       = 5,
    parameter bit          COUNT_ZEROS = 1'b0,
    parameter bit          COUNT_RUN   = 1'b0
) (
    input  logic [SIZE-1:0]  vec,
    input  fill_e            fill,
    output logic [CNT_W-1:0] cnt,
    output logic             contig,
    output logic             full
);

    logic [SIZE-1:0]  act;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] pop;
    logic             stop;

    assign act = COUNT_ZEROS ? ~vec : vec;

    // run stops at the first inactive bit seen from the fill end
    always_comb begin
        run  = '0;
        pop  = '0;
        stop = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (act[i]) begin
                pop = pop + CNT_W'(1);
            end
            if (!stop && ((fill == FillMsb) ? act[SIZE-1-i] : act[i])) begin
                run = run + CNT_W'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign contig = (run == pop);
    assign full   = &act;
    assign cnt    = COUNT_RUN ? run : pop;

endmodule

// File: rtl/row_col_dec.sv
// Rebuilds the DCO tuning word from the r_all/row/col capacitor selectors through
// a two-stage pipeline, flags illegal encodings and counts them (saturating).
module row_col_dec import row_col_dec_pkg::*; #(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned ROW_W     = ROW_W_DEF,
    parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic [size_of(ROW_W)-1:0]       r_all,
    input  logic [size_of(ROW_W)-1:0]       row,
    input  logic [size_of(ROW_W)-1:0]       col,
    input  logic                            err_clr,
    output logic [WORD_W-1:0]               word_out,
    output logic                            out_valid,
    output logic                            err,
    output logic [ERR_CODE_W-1:0]           err_code,
    output logic [ERR_CNT_W-1:0]            err_cnt
);

    localparam int unsigned SIZE  = size_of(ROW_W);
    localparam int unsigned CNT_W = ROW_W + 1;

    logic [SIZE-1:0] rall_q, row_q, col_q;
    logic            v1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rall_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            v1_q   <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                rall_q <= r_all;
                row_q  <= row;
                col_q  <= col;
            end
        end
    end

    logic [CNT_W-1:0] n_full, c_full;
    logic             rall_contig, rall_full, col_contig, col_full;
    fill_e            col_fill;

    // r_all is active-low: its zeros form the run from bit 0
    row_col_dec_therm_ones_cnt #(
        .SIZE        (SIZE),
        .CNT_W       (CNT_W),
        .COUNT_ZEROS (1'b1),
        .COUNT_RUN   (1'b1)
    ) u_rall_cnt (
        .vec    (rall_q),
        .fill   (FillLsb),
        .cnt    (n_full),
        .contig (rall_contig),
        .full   (rall_full)
    );

    // serpentine: odd rows fill the column from the top
    assign col_fill = n_full[0] ? FillMsb : FillLsb;

    row_col_dec_therm_ones_cnt #(
        .SIZE        (SIZE),
        .CNT_W       (CNT_W),
        .COUNT_ZEROS (1'b0),
        .COUNT_RUN   (1'b0)
    ) u_col_cnt (
        .vec    (col_q),
        .fill   (col_fill),
        .cnt    (c_full),
        .contig (col_contig),
        .full   (col_full)
    );

    logic [SIZE-1:0]       row_exp;
    logic                  rall_ok, row_ok, col_ok;
    logic [ERR_CODE_W-1:0] err_code_d;
    logic                  err_d;
    logic [WORD_W-1:0]     word_d;

    always_comb begin
        row_exp = {{(SIZE-1){1'b0}}, 1'b1} << n_full;
        rall_ok = rall_contig && !rall_full;
        row_ok  = !rall_full && (row_q == row_exp);
        col_ok  = col_contig && !col_full;

        err_code_d           = '0;
        err_code_d[ERR_RALL] = v1_q && !rall_ok;
        err_code_d[ERR_ROW]  = v1_q && !row_ok;
        err_code_d[ERR_COL]  = v1_q && !col_ok;
        err_d                = |err_code_d;

        word_d = '0;
        if (v1_q && !err_d) begin
            word_d = WORD_W'({n_full[ROW_W-1:0], c_full[ROW_W-1:0]});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_out  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else if (en) begin
            word_out  <= word_d;
            out_valid <= v1_q;
            err       <= err_d;
            err_code  <= err_code_d;
        end
    end

    // err_clr wins over a coincident increment and ignores en
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (en && err_d && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_row_col_dec.sv
// Scoreboard bench for row_col_dec: the driver queues expected results from a
// rule-level model, the monitor pops and compares whenever out_valid is produced.
module tb_row_col_dec;

    localparam int SIZE = 16;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic [15:0]   r_all, row, col;
    logic          err_clr;
    logic [7:0]    word_out;
    logic          out_valid;
    logic          err;
    logic [2:0]    err_code;
    logic [CW-1:0] err_cnt;

    row_col_dec #(
        .WORD_W    (8),
        .ROW_W     (4),
        .ERR_CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .r_all     (r_all),
        .row       (row),
        .col       (col),
        .err_clr   (err_clr),
        .word_out  (word_out),
        .out_valid (out_valid),
        .err       (err),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic       err;
        logic [2:0] code;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_edges = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Legality straight from the encoding rules: compare against canonical vectors.
    function automatic exp_t model(input logic [15:0] ra, input logic [15:0] ro,
                                   input logic [15:0] co);
        exp_t       x;
        int         n;
        int         c;
        logic [15:0] cexp;
        logic       ok_r, ok_w, ok_c;
        n = 0;
        while (n < 16 && ra[n] == 1'b0) n++;
        c    = $countones(co);
        ok_r = (n < 16) && (ra == 16'(~((32'd1 << n) - 32'd1)));
        ok_w = (n < 16) && (ro == 16'(32'd1 << n));
        if (n % 2 == 0) cexp = 16'((32'd1 << c) - 32'd1);
        else            cexp = 16'(((32'd1 << c) - 32'd1) << (16 - c));
        ok_c   = (c < 16) && (co == cexp);
        x.code = {!ok_c, !ok_w, !ok_r};
        x.err  = |x.code;
        x.word = x.err ? 8'h00 : {4'(n), 4'(c)};
        x.tag  = 0;
        return x;
    endfunction

    task automatic encode(input logic [7:0] w, output logic [15:0] ra, output logic [15:0] ro,
                          output logic [15:0] co);
        int n, c;
        n  = int'(w[7:4]);
        c  = int'(w[3:0]);
        ra = 16'(~((32'd1 << n) - 32'd1));
        ro = 16'(32'd1 << n);
        if (n % 2 == 0) co = 16'((32'd1 << c) - 32'd1);
        else            co = 16'(((32'd1 << c) - 32'd1) << (16 - c));
    endtask

    task automatic issue(input logic v, input logic e, input logic [15:0] ra,
                         input logic [15:0] ro, input logic [15:0] co, input exp_t x);
        exp_t y;
        @(negedge clk);
        in_valid = v;
        en       = e;
        r_all    = ra;
        row      = ro;
        col      = co;
        if (v && e) begin
            y     = x;
            y.tag = en_edges + 2;
            q.push_back(y);
        end
    endtask

    task automatic issue_m(input logic [15:0] ra, input logic [15:0] ro, input logic [15:0] co);
        issue(1'b1, 1'b1, ra, ro, co, model(ra, ro, co));
    endtask

    task automatic issue_x(input logic [15:0] ra, input logic [15:0] ro, input logic [15:0] co,
                           input logic [7:0] w, input logic [2:0] code);
        exp_t x;
        x.word = w;
        x.code = code;
        x.err  = |code;
        x.tag  = 0;
        issue(1'b1, 1'b1, ra, ro, co, x);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            in_valid = 1'b0;
            en       = 1'b1;
        end
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        err_clr  = 1'b1;
        @(negedge clk);
        err_clr  = 1'b0;
    endtask

    // Monitor: samples 1 ns after each rising edge, when en/err_clr still hold their edge value.
    exp_t last_exp;
    logic last_ov  = 1'b0;
    int   cnt_m    = 0;

    always begin
        exp_t e;
        logic inc;
        @(posedge clk);
        #1;
        inc = 1'b0;
        if (!rst) begin
            q.delete();
            cnt_m   = 0;
            last_ov = 1'b0;
        end else begin
            if (en) begin
                en_edges++;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("spurious_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("latency", en_edges, e.tag);
                        check("word_out", 32'(word_out), 32'(e.word));
                        check("err", 32'(err), 32'(e.err));
                        check("err_code", 32'(err_code), 32'(e.code));
                        last_exp = e;
                        inc      = e.err;
                    end
                    last_ov = 1'b1;
                end else begin
                    if (q.size() != 0 && q[0].tag <= en_edges) begin
                        check("missing_out_valid", 32'(out_valid), 32'd1);
                        void'(q.pop_front());
                    end
                    last_ov = 1'b0;
                end
            end else begin
                check("hold_out_valid", 32'(out_valid), 32'(last_ov));
                if (last_ov) check("hold_word_out", 32'(word_out), 32'(last_exp.word));
            end
            if (err_clr) cnt_m = 0;
            else if (inc && cnt_m != (1 << CW) - 1) cnt_m++;
            check("err_cnt", 32'(err_cnt), 32'(cnt_m));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] t_ra[4] = '{16'hFFFF, 16'hFFFC, 16'hFFF8, 16'h8000};
    logic [15:0] t_ro[4] = '{16'h0001, 16'h0004, 16'h0008, 16'h8000};
    logic [15:0] t_co[4] = '{16'h0000, 16'h0003, 16'hF800, 16'hFFFE};
    logic [7:0]  t_w[4]  = '{8'h00, 8'h22, 8'h35, 8'hFF};

    initial begin
        logic [15:0] ra, ro, co;
        logic [7:0]  w;
        rst      = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        r_all    = '0;
        row      = '0;
        col      = '0;
        err_clr  = 1'b0;

        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_word_out", 32'(word_out), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Legal directed codes, back to back
        for (int i = 0; i < 4; i++) issue_x(t_ra[i], t_ro[i], t_co[i], t_w[i], 3'b000);
        // Illegal directed codes
        issue_x(16'hFFFC, 16'h0006, 16'h0003, 8'h00, 3'b010);
        issue_x(16'hFFFE, 16'h0002, 16'h0003, 8'h00, 3'b100);
        issue_x(16'hFFF5, 16'h0001, 16'h0000, 8'h00, 3'b001);
        idle(3);

        // Stall with valid data on the inputs: nothing captured, nothing lost
        for (int i = 0; i < 3; i++) begin
            encode(8'(8'h41 + 8'(i * 19)), ra, ro, co);
            issue_m(ra, ro, co);
        end
        for (int i = 0; i < 3; i++) begin
            encode(8'hA7, ra, ro, co);
            issue(1'b1, 1'b0, ra, ro, co, model(ra, ro, co));
        end
        idle(4);

        // Saturation with a 2-bit counter, then clear coinciding with an increment
        clr_pulse();
        for (int i = 0; i < 5; i++) issue_m(16'hFFFC, 16'h0006, 16'h0003);
        idle(3);
        issue_m(16'hFFFC, 16'h0006, 16'h0003);
        clr_pulse();
        idle(2);
        check("err_cnt_after_clr", 32'(err_cnt), 32'd0);

        // Asynchronous reset with two words in flight
        issue_m(16'hFFFE, 16'h0004, 16'h0001);
        encode(8'h9C, ra, ro, co);
        issue_m(ra, ro, co);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_word_out", 32'(word_out), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_err_code", 32'(err_code), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(5);
        encode(8'h5A, ra, ro, co);
        issue_m(ra, ro, co);
        idle(3);

        // Exhaustive legal round trip
        for (int i = 0; i < 256; i++) begin
            encode(8'(i), ra, ro, co);
            issue_x(ra, ro, co, 8'(i), 3'b000);
        end
        idle(3);

        // Randomised traffic with corrupted codes, gaps and stalls
        for (int i = 0; i < 400; i++) begin
            w = 8'($urandom_range(0, 255));
            encode(w, ra, ro, co);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       ra = ra ^ (16'h1 << $urandom_range(0, 15));
                    1:       ro = ro ^ (16'h1 << $urandom_range(0, 15));
                    default: co = co ^ (16'h1 << $urandom_range(0, 15));
                endcase
            end
            err_clr = ($urandom_range(0, 29) == 0);
            issue(($urandom_range(0, 4) != 0), ($urandom_range(0, 6) != 0), ra, ro, co,
                  model(ra, ro, co));
        end
        @(negedge clk);
        err_clr = 1'b0;
        idle(4);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
